unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch path (PC -> instruction memory) and the load/store data path (ALU address -> data memory) of the RISC-V core.
- Sequences each access as a request/response transaction and drives a PC stall while a fetch is outstanding.
- Grants alternately under contention and aborts hung memory accesses with an error response.

---
 rtl/unified_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch path and the load/store path.
// Each access runs IDLE -> BUSY -> RESP; a hung BUSY phase is aborted with an error response.
module unified_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          err,
    output logic          pc_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic       PORT_IF = 1'b0;
    localparam logic       PORT_D  = 1'b1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          port_q, port_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic          if_valid_q, if_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          err_q, err_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          gnt;
    logic          done;
    logic          timed_out;
    logic [DW-1:0] rdata_cap;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        if_valid_d   = 1'b0;
        d_valid_d    = 1'b0;
        err_d        = 1'b0;
        gnt          = PORT_IF;
        done         = 1'b0;
        timed_out    = 1'b0;
        rdata_cap    = '0;
        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    // Under contention the port that did not win last time goes first
                    if (if_req && d_req) gnt = ~last_grant_q;
                    else                 gnt = d_req ? PORT_D : PORT_IF;
                    port_d       = gnt;
                    last_grant_d = gnt;
                    addr_d       = (gnt == PORT_D) ? d_addr : if_addr;
                    we_d         = (gnt == PORT_D) & d_we;
                    wdata_d      = (gnt == PORT_D) ? d_wdata : '0;
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = (gnt == PORT_D) & d_we;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_req_d = 1'b1;
                mem_we_d  = we_q;
                cnt_d     = cnt_q + 8'd1;
                if (mem_ready) begin
                    done      = 1'b1;
                    rdata_cap = mem_rdata;
                end else if (cnt_q == TO_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end
                if (done) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = timed_out;
                    if (port_q == PORT_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = rdata_cap;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!we_q) d_rdata_d = rdata_cap;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= PORT_D;
            port_q       <= PORT_IF;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            if_valid_q   <= 1'b0;
            d_valid_q    <= 1'b0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            if_valid_q   <= if_valid_d;
            d_valid_q    <= d_valid_d;
            err_q        <= err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign err       = err_q;
    assign pc_stall  = if_req & ~if_valid_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a vector table of single transactions against a
// small memory model, plus sequences for contention and reset during an access.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic        if_valid, d_valid, err, pc_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;

    int n_chk  = 0;
    int n_fail = 0;

    // Memory model: lat = BUSY cycle (1-based) in which mem_ready rises, 0 = never
    logic [31:0] mem_model [0:255];
    logic        init_mem;
    int          lat = 1;
    int          busy_cyc = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .err(err), .pc_stall(pc_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    assign mem_ready = mem_req && (lat != 0) && (busy_cyc == lat - 1);
    assign mem_rdata = mem_model[mem_addr[9:2]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 32'h0;
            mem_model[1]  <= 32'h0050_0093;
            mem_model[2]  <= 32'h0010_0113;
            mem_model[3]  <= 32'hFFFF_FFFF;
            mem_model[66] <= 32'hCAFE_0108;
        end else if (mem_req && mem_we && mem_ready) begin
            mem_model[mem_addr[9:2]] <= mem_wdata;
        end
        busy_cyc <= mem_req ? busy_cyc + 1 : 0;
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_if;
        logic [31:0] exp_d;
        int          exp_stall;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int   cyc, stall, busy;
        logic got, got_port, both, err_s, mem_bad;
        @(negedge clk);
        lat = v.lat;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        stall = pc_stall ? 1 : 0;
        cyc = 0; busy = 0; got = 1'b0; got_port = 1'b0; both = 1'b0; err_s = 1'b0; mem_bad = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (pc_stall) stall++;
            if (mem_req) begin
                busy++;
                if (mem_addr !== v.addr || mem_we !== v.we ||
                    (v.is_d && v.we && mem_wdata !== v.wdata)) mem_bad = 1'b1;
            end
            if (if_valid || d_valid) begin
                got = 1'b1; got_port = d_valid; both = if_valid && d_valid; err_s = err;
            end
        end
        if_req = 1'b0;
        d_req = 1'b0;
        chk({nm, " valid_seen"}, got, 1'b1);
        chk({nm, " latency"}, cyc, v.exp_cyc);
        chk({nm, " port"}, {both, got_port}, {1'b0, v.is_d});
        chk({nm, " err"}, err_s, v.exp_err);
        chk({nm, " if_rdata"}, if_rdata, v.exp_if);
        chk({nm, " d_rdata"}, d_rdata, v.exp_d);
        chk({nm, " busy_cycles"}, busy, v.exp_cyc - 1);
        chk({nm, " mem_stable"}, mem_bad, 1'b0);
        chk({nm, " pc_stall_cycles"}, stall, v.exp_stall);
        @(negedge clk);
        chk({nm, " resp_one_cycle"}, {if_valid, d_valid, err, mem_req}, 4'b0000);
    endtask

    initial begin
        int   cyc, nv, nif, nd, any;
        logic [3:0] order;
        logic both;
        //           is_d we  addr           wdata          lat cyc err exp_if         exp_d          stall
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         1,  2, 1'b0, 32'h0050_0093, 32'h0,         2};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1,  2, 1'b0, 32'h0050_0093, 32'h0,         0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1,  2, 1'b0, 32'h0050_0093, 32'hDEAD_BEEF, 0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         5,  6, 1'b0, 32'h0010_0113, 32'hDEAD_BEEF, 6};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678, 3,  4, 1'b0, 32'h0010_0113, 32'hDEAD_BEEF, 0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_000C, 32'h0,         0, 17, 1'b1, 32'h0,         32'hDEAD_BEEF, 17};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         1,  2, 1'b0, 32'h0050_0093, 32'hDEAD_BEEF, 2};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         2,  3, 1'b0, 32'h0050_0093, 32'h1234_5678, 0};
        vecs[8] = '{1'b1, 1'b1, 32'h0000_0108, 32'hAAAA_5555, 0, 17, 1'b1, 32'h0050_0093, 32'h1234_5678, 0};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,        16, 17, 1'b0, 32'h0050_0093, 32'hCAFE_0108, 0};

        reset = 1'b1; init_mem = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; init_mem = 1'b0;
        #1;
        chk("reset mem_req/we", {mem_req, mem_we}, 2'b00);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset valids/err/stall", {if_valid, d_valid, err, pc_stall}, 4'b0000);
        chk("reset if_rdata", if_rdata, 32'h0);
        chk("reset d_rdata", d_rdata, 32'h0);

        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Contention from reset: both ports held high for four back-to-back accesses
        do_reset();
        lat = 1; if_addr = 32'h4; d_addr = 32'h100; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        nv = 0; nif = 0; nd = 0; cyc = 0; order = 4'b0000; both = 1'b0;
        while (nv < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if_valid && d_valid) both = 1'b1;
            if (if_valid) begin order[nv] = 1'b0; nif++; nv++; end
            else if (d_valid) begin order[nv] = 1'b1; nd++; nv++; end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("contend grant_order", order, 4'b1010);
        chk("contend if_count", nif, 2);
        chk("contend d_count", nd, 2);
        chk("contend no_double_valid", both, 1'b0);
        chk("contend cycles", cyc, 11);
        chk("contend if_rdata", if_rdata, 32'h0050_0093);
        chk("contend d_rdata", d_rdata, 32'hDEAD_BEEF);

        // Reset in the third BUSY cycle of a hung fetch
        do_reset();
        lat = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h20;
        repeat (3) @(negedge clk);
        chk("midop busy3 mem_req", mem_req, 1'b1);
        reset = 1'b1; if_req = 1'b0;
        @(negedge clk);
        chk("midop after_reset mem", {mem_req, mem_we}, 2'b00);
        chk("midop after_reset pulses", {if_valid, d_valid, err}, 3'b000);
        reset = 1'b0;
        any = 0;
        repeat (20) begin
            @(negedge clk);
            if (if_valid || d_valid || err || mem_req) any++;
        end
        chk("midop quiet", any, 0);
        run_txn('{1'b0, 1'b0, 32'h8, 32'h0, 2, 3, 1'b0, 32'h0010_0113, 32'h0, 3}, "midop refetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
